bta_operand_loader: RTL and testbench
=====================================

Name: bta_operand_loader

Overview:
- Upstream feeder for the 8-operand binary-tree CLA adder.
- Accepts operands one word at a time over a valid/ready stream and assembles N operands plus a carry-in into a parallel bundle.
- Holds the bundle stable with a valid flag until the adder stage accepts it.
- Decouples the narrow serial source from the wide parallel adder inputs.

Parameters:
- N, 8, number of operands per batch (adder inputs A..H); power of two, ≥2.
- M, 16, operand width in bits.
- BW, 8, width of the completed-batch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the batch being filled.
- in_valid  input  1  source presents a word.
- in_ready  output  1  loader can accept a word.
- in_data  input  M  operand word.
- in_cin  input  1  carry-in; sampled only with word 0 of a batch.
- ops  output  N*M  operand k at ops[k*M +: M]; k=0 is A, k=N-1 is H.
- c0  output  1  carry-in for the adder (C0).
- ops_valid  output  1  bundle is complete and stable.
- ops_ready  input  1  adder stage accepts the bundle.
- fill_idx  output  $clog2(N)  next slot to be written.
- batch_cnt  output  BW  count of bundles handed off.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FILL, fill_idx=0, ops=0, c0=0, ops_valid=0, batch_cnt=0.
  - in_ready=1 during and after reset. It is combinational: in_ready = (state==FILL).
- States: FILL, HOLD.
- FILL, on each cycle with in_valid&&in_ready:
  - ops slot fill_idx <= in_data.
  - If fill_idx==0, c0 <= in_cin.
  - fill_idx increments.
  - When fill_idx==N-1 is accepted: fill_idx wraps to 0, state <= HOLD, ops_valid <= 1. ops_valid is seen high on the cycle after the last accept.
- FILL with in_valid=0: no change. Gaps between words are allowed at any point.
- HOLD:
  - in_ready=0; ops, c0 and ops_valid are frozen.
  - When ops_valid&&ops_ready: state <= FILL, ops_valid <= 0, batch_cnt increments (wraps modulo 2^BW).
  - in_ready returns high on the next cycle. This gives exactly one bubble cycle between the handoff and the next accept.
- ops_ready while in FILL: ignored.
- ops and c0 keep their last values after handoff until overwritten slot by slot. Downstream must sample only on ops_valid&&ops_ready.
- Latency: first word accepted at cycle t with no gaps gives ops_valid at t+N.
- flush=1 (synchronous, highest priority after reset):
  - state <= FILL, fill_idx <= 0, ops_valid <= 0.
  - ops, c0 and batch_cnt are unchanged.
  - A word presented in the same cycle is dropped, although in_ready may read 1.
  - A flush while in HOLD discards the pending bundle without a handoff; batch_cnt does not increment.
- Simultaneous last-word accept and flush: flush wins, no HOLD entry.
- Reset mid-batch: all state clears immediately. Partial operands are lost.
- No arithmetic is performed; widths pass through unchanged. The downstream adder produces an M+3-bit sum.

Decomposition:
- Shared package bta_pkg:
  - constants N_OPS=8, OP_W=16, SUM_W=OP_W+3.
  - state enum {FILL, HOLD}.
  - helper constant IDX_W=$clog2(N_OPS).
- Sub-module: bta_slot_reg, one M-bit register with load enable. Instantiated N times under a generate loop, indexed by fill_idx decode.
- Control FSM and counters stay in the top module.

Test Plan:
- Reset, then stream 8 back-to-back words 0x5E3A,0xF0AE,0x5ACA,0x6B3E,0x593A,0x480E,0x39DA,0x5CBE with in_cin=0 on word 0, ops_ready=1 → ops_valid high exactly 8 cycles after the first accept; ops slots A..H equal the words in order; c0=0; batch_cnt=1 the cycle after the handoff; in_ready low for exactly one cycle.
- Stall the handoff: complete a batch with ops_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout; ops frozen; no words consumed; handoff on the first cycle ops_ready=1.
- Gapped input: in_valid toggles 1,0,0,1,... over 8 words with in_cin=1 on word 0 and 0 on the rest → c0=1; fill_idx advances only on accepts; the bundle is correct.
- Flush at fill_idx=5, then 8 fresh words 0x0001..0x0008 → the new bundle holds 1..8 with no residue from the flushed batch; batch_cnt is unchanged by the flush.
- Flush in HOLD with ops_ready=0 → ops_valid drops the next cycle; batch_cnt is unchanged; in_ready=1.
- Assert rst_n=0 asynchronously mid-batch (between clock edges) → all outputs are zero immediately and in_ready=1. Run 256 batches → batch_cnt wraps to 0.

Source files
------------

// File: rtl/bta_pkg.sv
// Shared constants and state encoding for the binary-tree adder operand path.
package bta_pkg;

    localparam int unsigned N_OPS   = 8;
    localparam int unsigned OP_W    = 16;
    localparam int unsigned SUM_W   = OP_W + 3;
    localparam int unsigned IDX_W   = $clog2(N_OPS);
    localparam int unsigned BATCH_W = 8;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } bta_state_e;

endpackage

// File: rtl/bta_slot_reg.sv
// One operand slot: W-bit register with load enable, cleared by reset.
module bta_slot_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the incoming word only when this slot is addressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bta_operand_loader.sv
// Serial-to-parallel operand loader feeding the N-input binary-tree CLA adder.
// Words arrive over valid/ready, fill slots 0..N-1, then the bundle is held
// with ops_valid until the adder accepts it.
module bta_operand_loader
    import bta_pkg::*;
#(
    parameter int unsigned N  = N_OPS,
    parameter int unsigned M  = OP_W,
    parameter int unsigned BW = BATCH_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         in_data,
    input  logic                 in_cin,
    output logic [N*M-1:0]       ops,
    output logic                 c0,
    output logic                 ops_valid,
    input  logic                 ops_ready,
    output logic [$clog2(N)-1:0] fill_idx,
    output logic [BW-1:0]        batch_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [0:0] ST_FILL = 1'(FILL);
    localparam logic [0:0] ST_HOLD = 1'(HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [IW-1:0] fill_idx_d;
    logic          c0_d;
    logic          ops_valid_d;
    logic [BW-1:0] batch_cnt_d;
    logic [N-1:0]  load_en;

    // The loader is ready whenever it is filling; no lookahead on ops_ready.
    assign in_ready = (state_q == ST_FILL);

    // Next-state, slot decode and counter updates; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx;
        c0_d        = c0;
        ops_valid_d = ops_valid;
        batch_cnt_d = batch_cnt;
        load_en     = '0;

        if (flush) begin
            state_d     = ST_FILL;
            fill_idx_d  = '0;
            ops_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        load_en[fill_idx] = 1'b1;
                        if (fill_idx == '0) begin
                            c0_d = in_cin;
                        end
                        if (fill_idx == LAST_IDX) begin
                            fill_idx_d  = '0;
                            state_d     = ST_HOLD;
                            ops_valid_d = 1'b1;
                        end else begin
                            fill_idx_d = fill_idx + IW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (ops_valid && ops_ready) begin
                        state_d     = ST_FILL;
                        ops_valid_d = 1'b0;
                        batch_cnt_d = batch_cnt + BW'(1);
                    end
                end
                default: begin
                    state_d     = ST_FILL;
                    fill_idx_d  = '0;
                    ops_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            fill_idx  <= '0;
            c0        <= 1'b0;
            ops_valid <= 1'b0;
            batch_cnt <= '0;
        end else begin
            state_q   <= state_d;
            fill_idx  <= fill_idx_d;
            c0        <= c0_d;
            ops_valid <= ops_valid_d;
            batch_cnt <= batch_cnt_d;
        end
    end

    // One operand register per adder input, written when its slot is addressed.
    for (genvar k = 0; k < N; k++) begin : g_slot
        bta_slot_reg #(.W(M)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_en[k]),
            .d     (in_data),
            .q     (ops[k*M +: M])
        );
    end

endmodule

// File: tb/tb_bta_operand_loader.sv
// Directed bench for bta_operand_loader with a bundle scoreboard.
module tb_bta_operand_loader;

    localparam int unsigned N  = 8;
    localparam int unsigned M  = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned OW = N * M;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  in_data;
    logic          in_cin;
    logic [OW-1:0] ops;
    logic          c0;
    logic          ops_valid;
    logic          ops_ready;
    logic [2:0]    fill_idx;
    logic [BW-1:0] batch_cnt;

    bta_operand_loader #(.N(N), .M(M), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .ops       (ops),
        .c0        (c0),
        .ops_valid (ops_valid),
        .ops_ready (ops_ready),
        .fill_idx  (fill_idx),
        .batch_cnt (batch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int handoffs = 0;
    int exp_handoffs = 0;
    int cnt_model = 0;
    logic [OW:0] sb[$];

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one word and hold it until it is taken on a rising edge.
    task automatic send_word(input logic [M-1:0] d, input logic cin);
        int budget;
        logic rdy;
        budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = cin;
        rdy = in_ready;
        while (!rdy && budget < 50) begin
            step();
            budget++;
            rdy = in_ready;
        end
        if (!rdy) check("ready_timeout", 128'(rdy), 128'(1));
        step();
        in_valid = 1'b0;
    endtask

    // Push the expected bundle, then stream it with optional idle gaps.
    task automatic send_batch(input logic [OW-1:0] b, input logic cin, input int gap);
        for (int k = 0; k < int'(N); k++) begin
            send_word(b[k*M +: M], (k == 0) ? cin : ~cin);
            if (k == int'(N) - 1) begin
                sb.push_back({cin, b});
                exp_handoffs++;
            end
            repeat (gap) step();
        end
    endtask

    // Scoreboard: compare the held bundle at every handshake the DUT will take.
    always @(negedge clk) begin
        if (rst_n && ops_valid && ops_ready && !flush) begin
            logic [OW:0] e;
            handoffs++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_handoff observed=%0d expected=0", handoffs);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_ops", ops, e[OW-1:0]);
                check("sb_c0", 128'(c0), 128'(e[OW]));
            end
        end
    end

    logic [OW-1:0] b;
    logic [M-1:0]  w;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; ops_ready = 1'b0;
        #1;
        check("rst_ops", ops, '0);
        check("rst_valid", 128'(ops_valid), 128'(0));
        check("rst_ready", 128'(in_ready), 128'(1));
        check("rst_cnt", 128'(batch_cnt), 128'(0));
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back batch with latency and bubble checks.
        b = {16'h5CBE, 16'h39DA, 16'h480E, 16'h593A, 16'h6B3E, 16'h5ACA, 16'hF0AE, 16'h5E3A};
        ops_ready = 1'b1;
        sb.push_back({1'b0, b});
        exp_handoffs++;
        for (int k = 0; k < int'(N); k++) begin
            in_valid = 1'b1;
            in_data  = b[k*M +: M];
            in_cin   = (k == 0) ? 1'b0 : 1'b1;
            step();
            check("t1_fill_idx", 128'(fill_idx), 128'((k + 1) % int'(N)));
            check("t1_valid", 128'(ops_valid), 128'(k == int'(N) - 1));
        end
        in_valid = 1'b0;
        check("t1_ready_low", 128'(in_ready), 128'(0));
        check("t1_c0", 128'(c0), 128'(0));
        check("t1_ops", ops, b);
        step();
        cnt_model++;
        check("t1_ready_back", 128'(in_ready), 128'(1));
        check("t1_cnt", 128'(batch_cnt), 128'(cnt_model));

        // Stalled handoff: source keeps pushing while bundle is held.
        ops_ready = 1'b0;
        for (int k = 0; k < int'(N); k++) b[k*M +: M] = 16'(k * 16'h1111 + 3);
        send_batch(b, 1'b1, 0);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            check("t2_ready", 128'(in_ready), 128'(0));
            check("t2_ops_frozen", ops, b);
            check("t2_idx", 128'(fill_idx), 128'(0));
            step();
        end
        in_valid  = 1'b0;
        ops_ready = 1'b1;
        step();
        cnt_model++;
        check("t2_valid_drop", 128'(ops_valid), 128'(0));
        check("t2_cnt", 128'(batch_cnt), 128'(cnt_model));

        // Gapped input, carry-in only from word 0.
        for (int k = 0; k < int'(N); k++) b[k*M +: M] = 16'($urandom);
        for (int k = 0; k < int'(N); k++) begin
            send_word(b[k*M +: M], k == 0);
            check("t3_idx_accept", 128'(fill_idx), 128'((k + 1) % int'(N)));
            if (k == int'(N) - 1) begin
                sb.push_back({1'b1, b});
                exp_handoffs++;
                check("t3_c0", 128'(c0), 128'(1));
            end else begin
                step();
                step();
                check("t3_idx_gap", 128'(fill_idx), 128'(k + 1));
            end
        end
        step();
        step();
        cnt_model++;
        check("t3_cnt", 128'(batch_cnt), 128'(cnt_model));

        // Flush at slot 5, word in the flush cycle is dropped.
        for (int k = 0; k < 5; k++) begin
            w = 16'hA000 + 16'(k);
            send_word(w, 1'b1);
        end
        check("t4_idx5", 128'(fill_idx), 128'(5));
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hBBBB;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_idx0", 128'(fill_idx), 128'(0));
        check("t4_cnt_same", 128'(batch_cnt), 128'(cnt_model));
        for (int k = 0; k < int'(N); k++) b[k*M +: M] = 16'(k + 1);
        send_batch(b, 1'b0, 0);
        step();
        cnt_model++;
        check("t4_cnt", 128'(batch_cnt), 128'(cnt_model));

        // Flush while holding discards the bundle without a handoff.
        ops_ready = 1'b0;
        for (int k = 0; k < int'(N); k++) b[k*M +: M] = 16'($urandom);
        send_batch(b, 1'b1, 0);
        check("t5_valid", 128'(ops_valid), 128'(1));
        void'(sb.pop_back());
        exp_handoffs--;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_valid_drop", 128'(ops_valid), 128'(0));
        check("t5_cnt", 128'(batch_cnt), 128'(cnt_model));
        check("t5_ready", 128'(in_ready), 128'(1));
        check("t5_ops_kept", ops, b);

        // Asynchronous reset mid-batch.
        ops_ready = 1'b1;
        for (int k = 0; k < 3; k++) send_word(16'h7700 + 16'(k), 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_ops", ops, '0);
        check("t6_c0", 128'(c0), 128'(0));
        check("t6_valid", 128'(ops_valid), 128'(0));
        check("t6_cnt", 128'(batch_cnt), 128'(0));
        check("t6_idx", 128'(fill_idx), 128'(0));
        check("t6_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        cnt_model = 0;
        step();

        // 256 batches so the counter wraps.
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < int'(N); k++) b[k*M +: M] = 16'($urandom);
            send_batch(b, 1'($urandom), 0);
            step();
            cnt_model = (cnt_model + 1) % 256;
            check("t6_wrap_cnt", 128'(batch_cnt), 128'(cnt_model));
        end
        check("t6_wrapped", 128'(batch_cnt), 128'(0));

        step();
        check("sb_drained", 128'(sb.size()), 128'(0));
        check("handoff_count", 128'(handoffs), 128'(exp_handoffs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
